// File: rtl/common_arb_pkg.sv
// Shared arbitration types and helpers.
// Used by round-robin style schedulers.
package common_arb_pkg;

  localparam int ARB_MAX_REQ = 32;
  localparam int ARB_IDX_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan pointer, pointer+1, ... and return the first live request.
  // Bits above the caller's requester count are zero, so wrapping
  // modulo ARB_MAX_REQ visits the same order as wrapping at NUM_REQ.
  function automatic rr_pick_t rr_next_idx(
    input logic [ARB_MAX_REQ-1:0] req,
    input logic [ARB_IDX_W-1:0]   pointer,
    input logic                   exclude_en,
    input logic [ARB_IDX_W-1:0]   exclude_idx
  );
    rr_pick_t             r;
    logic [ARB_IDX_W-1:0] k;
    r = '0;
    for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
      k = pointer + ARB_IDX_W'(i);
      if (req[k] && !(exclude_en && (k == exclude_idx))) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/one_hot_decoder.sv
// Binary index to one-hot vector.
// Pure combinational decode.
module one_hot_decoder #(
  parameter int INPUT_WIDTH = 2
) (
  input  logic [INPUT_WIDTH-1:0]    in_i,
  output logic [2**INPUT_WIDTH-1:0] out_o
);

  localparam int OUT_W = 2**INPUT_WIDTH;

  // Shift a single set bit into position.
  always_comb begin
    out_o = OUT_W'(1) << in_i;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler with hold-time preemption.
// Registered index drives a one-hot select.
module rr_grant_scheduler
  import common_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ),
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 preempt
);

  localparam int CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam bit HAS_LIMIT = (MAX_HOLD > 0);
  localparam int LIM = HAS_LIMIT ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] HOLD_SAT =
    HAS_LIMIT ? CW'(LIM) : '1;
  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pre_q, pre_d;

  logic [ARB_MAX_REQ-1:0] req_ext;
  logic [IDX_WIDTH-1:0]   ptr_nxt;
  logic                   own_req;
  logic                   at_limit;
  logic                   cut;
  rr_pick_t               pick_idle;
  rr_pick_t               pick_next;

  assign req_ext  = ARB_MAX_REQ'(req);
  assign ptr_nxt  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign own_req  = req[idx_q];
  assign at_limit = HAS_LIMIT && (cnt_q == CW'(LIM));

  // Candidate winners: from the fairness pointer when idle, and
  // from just past the owner (owner last) when handing over.
  always_comb begin
    pick_idle = rr_next_idx(req_ext, ARB_IDX_W'(ptr_q),
                            1'b0, '0);
    pick_next = rr_next_idx(req_ext, ARB_IDX_W'(ptr_nxt),
                            1'b1, ARB_IDX_W'(idx_q));
  end

  assign cut = !own_req || (at_limit && pick_next.found);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state: arbitrate, hold, release or preempt.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          idx_d   = IDX_WIDTH'(pick_idle.idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cut) begin
          ptr_d = ptr_nxt;
          cnt_d = '0;
          if (pick_next.found) begin
            idx_d = IDX_WIDTH'(pick_next.idx);
            pre_d = own_req;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (cnt_q != HOLD_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [2**IDX_WIDTH-1:0] dec;

  one_hot_decoder #(
    .INPUT_WIDTH(IDX_WIDTH)
  ) u_dec (
    .in_i (idx_q),
    .out_o(dec)
  );

  generate
    if (NUM_REQ < 2**IDX_WIDTH) begin : g_trim
      logic dec_unused;
      assign dec_unused = |dec[2**IDX_WIDTH-1:NUM_REQ];
    end
  endgenerate

  // Outputs: pure decode of registered state.
  always_comb begin
    grant_valid = (state_q == GRANT);
    grant_idx   = idx_q;
    preempt     = pre_q;
    grant       = dec[NUM_REQ-1:0] & {NUM_REQ{grant_valid}};
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Randomised bench for rr_grant_scheduler.
// Behavioural model checked every cycle.
module tb_rr_grant_scheduler;

  localparam int N  = 4;
  localparam int MH = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_valid;
  logic         preempt;

  rr_grant_scheduler #(
    .NUM_REQ (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Reference model: owner, fairness pointer, cycles held.
  bit m_valid;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_pre;

  task automatic m_reset();
    m_valid = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_pre   = 0;
  endtask

  function automatic int scan(input logic [N-1:0] r,
                              input int start,
                              input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [N-1:0] r);
    int w;
    bit own;
    m_pre = 0;
    if (!m_valid) begin
      w = scan(r, m_ptr, -1);
      if (w >= 0) begin
        m_valid = 1;
        m_owner = w;
        m_held  = 1;
      end
    end else begin
      own = r[m_owner];
      w   = scan(r, (m_owner + 1) % N, m_owner);
      if (!own || (m_held >= MH && w >= 0)) begin
        m_ptr = (m_owner + 1) % N;
        if (w >= 0) begin
          m_pre   = own;
          m_owner = w;
          m_held  = 1;
        end else begin
          m_valid = 0;
          m_owner = 0;
          m_held  = 0;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = m_valid ? N'(1 << m_owner) : '0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(m_owner));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
  endtask

  task automatic cycle(input logic [N-1:0] r,
                       input string tag);
    req = r;
    @(posedge clk);
    m_step(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int           seen[$];
  int           n_pre;
  logic [N-1:0] r;

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.grant", 32'(grant), 0);
    chk("rst.valid", 32'(grant_valid), 0);
    chk("rst.idx", 32'(grant_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, "first");
    chk("first.idx0", 32'(grant_idx), 0);

    // Fairness: each owner drops after 3 cycles of service.
    do_reset();
    seen.delete();
    for (int c = 0; c < 20; c++) begin
      r = 4'b1111;
      if (m_valid && m_held == 3) r[m_owner] = 1'b0;
      cycle(r, "fair");
      if (grant_valid &&
          (seen.size() == 0 || seen[$] != int'(grant_idx)))
        seen.push_back(int'(grant_idx));
    end
    chk("fair.len", 32'(seen.size() >= 5), 1);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk("fair.order", 32'(seen[i]), 32'(i % N));

    // Single requester holds well past the limit.
    do_reset();
    n_pre = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(4'b0100, "single");
      n_pre += int'(preempt);
    end
    chk("single.grant", 32'(grant), 32'h4);
    chk("single.npre", 32'(n_pre), 0);

    // Preemption: req[3] joins while 1 holds.
    do_reset();
    n_pre = 0;
    for (int c = 0; c < 5; c++) cycle(4'b0010, "pre");
    for (int c = 0; c < 25; c++) begin
      cycle(4'b1010, "pre");
      n_pre += int'(preempt);
    end
    chk("pre.count", 32'(n_pre), 1);
    chk("pre.owner", 32'(grant_idx), 3);
    // Limit reached, then other requester appears later.
    for (int c = 0; c < 20; c++) cycle(4'b1000, "pre2");
    for (int c = 0; c < 3; c++) cycle(4'b1001, "pre2");
    chk("pre2.owner", 32'(grant_idx), 0);

    // Back-to-back release then pointer honoured.
    do_reset();
    for (int c = 0; c < 3; c++) cycle(4'b0100, "b2b");
    cycle(4'b0001, "b2b");
    chk("b2b.grant", 32'(grant), 32'h1);
    cycle(4'b0000, "b2b");
    cycle(4'b1001, "b2b");
    chk("b2b.next", 32'(grant_idx), 3);

    // Async reset mid-grant.
    do_reset();
    cycle(4'b0010, "ar");
    cycle(4'b0010, "ar");
    chk("ar.pre", 32'(grant), 32'h2);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar.grant", 32'(grant), 0);
    chk("ar.valid", 32'(grant_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, "ar.restart");
    chk("ar.restart0", 32'(grant_idx), 0);

    // Random traffic, sticky requests with occasional flips.
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ((c / 500) % 2 == 1 && $urandom_range(0, 3) != 0)
        r = r | 4'b1010;
      cycle(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
